// File: rtl/bcd2bin_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
// Build option: BCD2BIN_CLAMP_EN (see bcd2bin_seq.sv).
package bcd2bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_BIN_W  = 14;

  // Smallest width w with 2^w > 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    longint unsigned limit;
    int w;
    limit = 1;
    for (int i = 0; i < digits; i++) limit = limit * 10;
    w = 0;
    while ((64'd1 << w) < limit) w++;
    return w;
  endfunction

  function automatic logic digit_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit cell: a digit that reached 8 or more after the
// right shift had a borrowed ten's half, so subtract 3 to restore BCD.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd8) ? d - 4'd3 : d;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter with start/done handshake.
// Build option BCD2BIN_CLAMP_EN: invalid digits are clamped to 9 instead of aborting.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BCD_W-1:0]   bcd_field;
  logic [BIN_W-1:0]   bin_field;
  logic [CNT_W-1:0]   count;
  logic               err_next;

  logic [SR_W-1:0]    sr_shift;
  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_shift;
  logic [BCD_W-1:0]   bcd_cap;
  logic               in_bad;

  assign sr_shift  = {bcd_field, bin_field} >> 1;
  assign bcd_shift = sr_shift[SR_W-1:BIN_W];
  assign bin_shift = sr_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (bcd_shift[4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_bad  = 1'b0;
    bcd_cap = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (!digit_valid(bcd_in[4*i +: 4])) begin
        in_bad = 1'b1;
`ifdef BCD2BIN_CLAMP_EN
        bcd_cap[4*i +: 4] = 4'd9;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bcd_field <= '0;
      bin_field <= '0;
      count     <= '0;
      err_next  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_field <= bcd_cap;
            bin_field <= '0;
            count     <= '0;
            err_next  <= in_bad;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
`ifndef BCD2BIN_CLAMP_EN
          // Invalid input: spend this one SHIFT cycle without shifting, then report.
          if (err_next) begin
            bin_out <= '0;
            err     <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else
`endif
          begin
            bcd_field <= bcd_adj;
            bin_field <= bin_shift;
            count     <= count + 1'b1;
            if (count == CNT_W'(BIN_W - 1)) begin
              bin_out <= bin_shift;
              err     <= err_next;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq; expected values are hand-computed decimal conversions.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int total = 0;
  int bad   = 0;

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One conversion; optionally pulses start with 5678 at cycle ign_at while busy.
  task automatic run(input string tag, input logic [15:0] bcd, input logic [13:0] exp_bin,
                     input logic exp_err, input int exp_lat, input int ign_at);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    logic [13:0] held;
    @(negedge clk);
    start  = 1'b1;
    bcd_in = bcd;
    while (cyc < 40 && !seen) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        start  = 1'b0;
        bcd_in = 16'hFFFF;
      end
      if (ign_at > 0 && cyc == ign_at) begin
        check({tag, "_busy_mid"}, 32'(busy), 32'd1);
        start  = 1'b1;
        bcd_in = 16'h5678;
      end
      if (ign_at > 0 && cyc == ign_at + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1;
    end
    check({tag, "_latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
    check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    if (exp_lat == 15) check({tag, "_bcd_zero"}, 32'(dut.bcd_field), 32'd0);
    // Start during the DONE cycle must be ignored.
    held   = bin_out;
    start  = 1'b1;
    bcd_in = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"}, 32'(bin_out), 32'(held));
  endtask

  initial begin
    int cyc;
    int pulses;
    int prev;
    int spurious;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = 16'h0000;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("c9999", 16'h9999, 14'd9999, 1'b0, 15, 0);
    run("c0000", 16'h0000, 14'd0,    1'b0, 15, 0);
    run("c1234", 16'h1234, 14'd1234, 1'b0, 15, 0);
    run("c0100", 16'h0100, 14'd100,  1'b0, 15, 0);
`ifdef BCD2BIN_CLAMP_EN
    run("c12A4", 16'h12A4, 14'd1294, 1'b1, 15, 0);
`else
    run("c12A4", 16'h12A4, 14'd0,    1'b1, 2,  0);
`endif
    run("ign1234", 16'h1234, 14'd1234, 1'b0, 15, 5);
    run("c5678",   16'h5678, 14'd5678, 1'b0, 15, 0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h9999;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bin", 32'(bin_out), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    spurious = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    check("midrst_no_done", 32'(spurious), 32'd0);
    run("c0042", 16'h0042, 14'd42, 1'b0, 15, 0);

    // Start held high: one conversion every 16 cycles.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0001;
    pulses = 0;
    prev   = -1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (prev >= 0) check("b2b_gap", 32'(cyc - prev), 32'd16);
        check("b2b_bin", 32'(bin_out), 32'd1);
        prev = cyc;
      end
    end
    start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_first", 32'(prev), 32'd47);
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
